// File: rtl/z88_rom_shadow.sv
// z88_rom_shadow: boot-time flash-to-SRAM copy engine and memory-bus mux.
// While copying, the engine owns the flash and SRAM pins and the Z88 core is
// held in reset. Once the block is copied, both buses become combinational
// pass-through from the core and the core reset is released.
//
// Request semantics: reload is a single-cycle pulse. It is only accepted in
// DONE; in every other state it is dropped, with no queueing or back-pressure.
module z88_rom_shadow #(
    parameter logic [18:0] SRC_BASE = 19'h00000,
    parameter logic [18:0] DST_BASE = 19'h40000,
    parameter logic [19:0] LEN      = 20'h40000,
    parameter int          FL_WAIT  = 4,
    parameter int          SRAM_WE  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reload,
    input  logic [18:0] z_ram_a,
    input  logic [7:0]  z_ram_di,
    input  logic        z_ram_ce_n,
    input  logic        z_ram_oe_n,
    input  logic        z_ram_we_n,
    input  logic [18:0] z_rom_a,
    input  logic        z_rom_ce_n,
    input  logic        z_rom_oe_n,
    input  logic [7:0]  fl_do,
    output logic [18:0] fl_a,
    output logic        fl_ce_n,
    output logic        fl_oe_n,
    output logic [18:0] sram_a,
    output logic [7:0]  sram_di,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        z88_rst_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WSETUP = 3'd2,
        S_WPULSE = 3'd3,
        S_WHOLD  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [19:0] LAST_IDX = LEN - 20'd1;
    // fl_do arrives one clock after fl_a, so data is taken on the last READ cycle.
    localparam logic [3:0]  FL_LAST  = 4'(FL_WAIT - 1);
    localparam logic [3:0]  WE_LAST  = 4'(SRAM_WE - 1);

    state_t      state_q, state_d;
    logic [19:0] idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] sum_q, sum_d;
    logic [18:0] eng_fl_a;
    logic [18:0] eng_sram_a;

    // Both addresses wrap modulo 2^19 through the 19-bit add.
    assign eng_fl_a   = SRC_BASE + idx_q[18:0];
    assign eng_sram_a = DST_BASE + idx_q[18:0];

    assign checksum  = sum_q;
    assign dbg_state = state_q;

    // Engine registers; reset drops straight back to IDLE with cleared counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= 20'd0;
            cnt_q   <= 4'd0;
            data_q  <= 8'd0;
            sum_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state logic: per byte READ x FL_WAIT, WSETUP, WPULSE x SRAM_WE, WHOLD.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_READ;
                idx_d   = 20'd0;
                cnt_d   = 4'd0;
                sum_d   = 16'd0;
            end
            S_READ: begin
                if (cnt_q == FL_LAST) begin
                    data_d  = fl_do;
                    sum_d   = sum_q + {8'h00, fl_do};
                    cnt_d   = 4'd0;
                    state_d = S_WSETUP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WSETUP: begin
                cnt_d   = 4'd0;
                state_d = S_WPULSE;
            end
            S_WPULSE: begin
                if (cnt_q == WE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_WHOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WHOLD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 20'd1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                if (reload) begin
                    state_d = S_READ;
                    idx_d   = 20'd0;
                    cnt_d   = 4'd0;
                    sum_d   = 16'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin mux: engine drives the buses while copying, the core owns them in DONE.
    always_comb begin
        fl_a      = 19'd0;
        fl_ce_n   = 1'b1;
        fl_oe_n   = 1'b1;
        sram_a    = 19'd0;
        sram_di   = 8'd0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        z88_rst_n = 1'b0;
        case (state_q)
            S_READ: begin
                busy    = 1'b1;
                fl_a    = eng_fl_a;
                fl_ce_n = 1'b0;
                fl_oe_n = 1'b0;
            end
            S_WSETUP, S_WHOLD: begin
                busy      = 1'b1;
                sram_a    = eng_sram_a;
                sram_di   = data_q;
                sram_ce_n = 1'b0;
            end
            S_WPULSE: begin
                busy      = 1'b1;
                sram_a    = eng_sram_a;
                sram_di   = data_q;
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
            end
            S_DONE: begin
                done      = 1'b1;
                z88_rst_n = 1'b1;
                fl_a      = z_rom_a;
                fl_ce_n   = z_rom_ce_n;
                fl_oe_n   = z_rom_oe_n;
                sram_a    = z_ram_a;
                sram_di   = z_ram_di;
                sram_ce_n = z_ram_ce_n;
                sram_oe_n = z_ram_oe_n;
                sram_we_n = z_ram_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_z88_rom_shadow.sv
// Bench for z88_rom_shadow: a 16-byte copy engine plus a second instance whose
// destination wraps past the top of the 19-bit SRAM space.
module tb_z88_rom_shadow;

    localparam logic [18:0] SRC     = 19'h00000;
    localparam logic [18:0] DST     = 19'h40000;
    localparam logic [18:0] DST_W   = 19'h7FFF8;
    localparam logic [19:0] NBYTES  = 20'd16;
    localparam int          FLW     = 4;
    localparam int          WEW     = 2;
    localparam int          DONE_AT = 1 + 16 * (FLW + WEW + 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, rst_w_n, reload;
    logic [18:0] z_ram_a, z_rom_a;
    logic [7:0]  z_ram_di;
    logic        z_ram_ce_n, z_ram_oe_n, z_ram_we_n, z_rom_ce_n, z_rom_oe_n;
    logic [7:0]  fl_do = 8'd0;
    logic [7:0]  fl_do_w = 8'd0;

    logic [18:0] fl_a, sram_a, fl_a_w, sram_a_w;
    logic [7:0]  sram_di, sram_di_w;
    logic        fl_ce_n, fl_oe_n, sram_ce_n, sram_oe_n, sram_we_n;
    logic        fl_ce_n_w, fl_oe_n_w, sram_ce_n_w, sram_oe_n_w, sram_we_n_w;
    logic        z88_rst_n, busy, done, z88_rst_n_w, busy_w, done_w;
    logic [15:0] checksum, checksum_w;
    logic [2:0]  dbg_state, dbg_state_w;

    z88_rom_shadow #(.SRC_BASE(SRC), .DST_BASE(DST), .LEN(NBYTES),
                     .FL_WAIT(FLW), .SRAM_WE(WEW)) dut (
        .clk(clk), .reset_n(reset_n), .reload(reload),
        .z_ram_a(z_ram_a), .z_ram_di(z_ram_di), .z_ram_ce_n(z_ram_ce_n),
        .z_ram_oe_n(z_ram_oe_n), .z_ram_we_n(z_ram_we_n),
        .z_rom_a(z_rom_a), .z_rom_ce_n(z_rom_ce_n), .z_rom_oe_n(z_rom_oe_n),
        .fl_do(fl_do), .fl_a(fl_a), .fl_ce_n(fl_ce_n), .fl_oe_n(fl_oe_n),
        .sram_a(sram_a), .sram_di(sram_di), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .z88_rst_n(z88_rst_n), .busy(busy), .done(done),
        .checksum(checksum), .dbg_state(dbg_state)
    );

    z88_rom_shadow #(.SRC_BASE(SRC), .DST_BASE(DST_W), .LEN(NBYTES),
                     .FL_WAIT(FLW), .SRAM_WE(WEW)) dut_w (
        .clk(clk), .reset_n(rst_w_n), .reload(1'b0),
        .z_ram_a(19'h00000), .z_ram_di(8'h00), .z_ram_ce_n(1'b1),
        .z_ram_oe_n(1'b1), .z_ram_we_n(1'b1),
        .z_rom_a(19'h00000), .z_rom_ce_n(1'b1), .z_rom_oe_n(1'b1),
        .fl_do(fl_do_w), .fl_a(fl_a_w), .fl_ce_n(fl_ce_n_w), .fl_oe_n(fl_oe_n_w),
        .sram_a(sram_a_w), .sram_di(sram_di_w), .sram_ce_n(sram_ce_n_w),
        .sram_oe_n(sram_oe_n_w), .sram_we_n(sram_we_n_w),
        .z88_rst_n(z88_rst_n_w), .busy(busy_w), .done(done_w),
        .checksum(checksum_w), .dbg_state(dbg_state_w)
    );

    // Flash model: contents are addr[7:0]^A5, registered once like the top does.
    function automatic logic [7:0] flash_byte(input logic [18:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        fl_do   <= flash_byte(fl_a);
        fl_do_w <= flash_byte(fl_a_w);
    end

    // ---------------- scoreboard ----------------
    logic [26:0] exp_q[$];
    logic [26:0] exp_w_q[$];
    logic [15:0] exp_sum, exp_sum_w;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_copy();
        logic [18:0] sa;
        logic [7:0]  b;
        exp_sum = 16'd0;
        for (int i = 0; i < 16; i++) begin
            sa = SRC + 19'(i);
            b  = flash_byte(sa);
            exp_q.push_back({DST + 19'(i), b});
            exp_sum = exp_sum + {8'h00, b};
        end
    endtask

    task automatic push_copy_w();
        logic [18:0] sa;
        logic [7:0]  b;
        exp_sum_w = 16'd0;
        for (int i = 0; i < 16; i++) begin
            sa = SRC + 19'(i);
            b  = flash_byte(sa);
            exp_w_q.push_back({DST_W + 19'(i), b});
            exp_sum_w = exp_sum_w + {8'h00, b};
        end
    endtask

    task automatic randomize_z();
        z_ram_a    = 19'($urandom);
        z_ram_di   = 8'($urandom);
        z_ram_ce_n = 1'($urandom_range(0, 1));
        z_ram_oe_n = 1'($urandom_range(0, 1));
        z_ram_we_n = 1'($urandom_range(0, 1));
        z_rom_a    = 19'($urandom);
        z_rom_ce_n = 1'($urandom_range(0, 1));
        z_rom_oe_n = 1'($urandom_range(0, 1));
    endtask

    // Counts rising edges until done; optionally pulses reload inside byte 5.
    task automatic wait_done(input int start, input bit poke, output int cyc);
        cyc = start;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            reload = poke && (cyc == 43);
            randomize_z();
            if (done) break;
        end
        reload = 1'b0;
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- bus monitors ----------------
    int          fl_run = 0, we_run = 0, overlap_cnt = 0, unstable_cnt = 0, overlap_w = 0;
    logic        prev_we = 1'b1, prev_ce = 1'b1, prev_we_w = 1'b1;
    logic [18:0] prev_a = 19'd0;
    logic [7:0]  prev_di = 8'd0;
    logic [26:0] e;

    always @(negedge clk) begin
        if (reset_n && busy) begin
            if (!fl_ce_n && !sram_ce_n) overlap_cnt++;
            if (!fl_oe_n) fl_run++;
            else if (fl_run != 0) begin
                check("fl_oe_len", 32'(fl_run), 32'(FLW));
                fl_run = 0;
            end
            if (!sram_we_n) begin
                if (prev_we) begin
                    if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("sram_wr", {5'd0, sram_a, sram_di}, {5'd0, e});
                    end
                end
                we_run++;
            end else if (we_run != 0) begin
                check("we_len", 32'(we_run), 32'(WEW));
                we_run = 0;
            end
            if (!sram_ce_n && !prev_ce && ({sram_a, sram_di} != {prev_a, prev_di}))
                unstable_cnt++;
            prev_we = sram_we_n;
            prev_ce = sram_ce_n;
            prev_a  = sram_a;
            prev_di = sram_di;
        end else begin
            fl_run  = 0;
            we_run  = 0;
            prev_we = 1'b1;
            prev_ce = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_w_n && busy_w) begin
            if (!fl_ce_n_w && !sram_ce_n_w) overlap_w++;
            if (!sram_we_n_w && prev_we_w) begin
                if (exp_w_q.size() == 0) check("sb_w_extra", 32'd1, 32'd0);
                else begin
                    e = exp_w_q.pop_front();
                    check("sram_wr_wrap", {5'd0, sram_a_w, sram_di_w}, {5'd0, e});
                end
            end
            prev_we_w = sram_we_n_w;
        end else begin
            prev_we_w = 1'b1;
        end
    end

    // ---------------- test sequence ----------------
    int          cyc;
    logic [15:0] first_sum;

    initial begin
        reset_n = 1'b0;
        rst_w_n = 1'b0;
        reload  = 1'b0;
        randomize_z();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_z88", 32'(z88_rst_n), 32'd0);
        check("rst_sum", 32'(checksum), 32'd0);
        check("rst_fl_str", {30'd0, fl_ce_n, fl_oe_n}, 32'd3);
        check("rst_sram_str", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        check("rst_fl_a", 32'(fl_a), 32'd0);
        check("rst_sram_a", 32'(sram_a), 32'd0);
        check("rst_sram_di", 32'(sram_di), 32'd0);

        // First copy, with a reload pulse during byte 5 that must be ignored.
        push_copy();
        push_copy_w();
        @(negedge clk);
        reset_n = 1'b1;
        rst_w_n = 1'b1;
        wait_done(0, 1'b1, cyc);
        check("done_latency", 32'(cyc), 32'(DONE_AT));
        check("checksum", 32'(checksum), 32'(exp_sum));
        check("checksum_val", 32'(checksum), 32'h0A78);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        first_sum = checksum;

        // Wrap instance finished in lockstep.
        check("wrap_done", 32'(done_w), 32'd1);
        check("wrap_sum", 32'(checksum_w), 32'(exp_sum_w));
        check("wrap_sb_left", 32'(exp_w_q.size()), 32'd0);
        check("wrap_overlap", 32'(overlap_w), 32'd0);
        check("wrap_state", 32'(dbg_state_w), 32'd5);
        check("wrap_z88", 32'(z88_rst_n_w), 32'd1);
        check("wrap_pass_oe", {30'd0, fl_oe_n_w, sram_oe_n_w}, 32'd3);

        // Pass-through in DONE is combinational: no clock edge in between.
        z_ram_a    = 19'h12345;
        z_ram_di   = 8'h5A;
        z_ram_ce_n = 1'b0;
        z_ram_oe_n = 1'b1;
        z_ram_we_n = 1'b0;
        z_rom_a    = 19'h00ABC;
        z_rom_ce_n = 1'b0;
        z_rom_oe_n = 1'b0;
        #1;
        check("pt_sram_a", 32'(sram_a), 32'h12345);
        check("pt_sram_we", 32'(sram_we_n), 32'd0);
        check("pt_sram_di", 32'(sram_di), 32'h5A);
        check("pt_sram_ce_oe", {30'd0, sram_ce_n, sram_oe_n}, 32'd1);
        check("pt_fl_a", 32'(fl_a), 32'h00ABC);
        check("pt_fl_str", {30'd0, fl_ce_n, fl_oe_n}, 32'd0);
        check("pt_z88", 32'(z88_rst_n), 32'd1);
        check("pt_busy", 32'(busy), 32'd0);
        z_ram_ce_n = 1'b1;
        z_ram_oe_n = 1'b1;
        z_ram_we_n = 1'b1;
        z_rom_ce_n = 1'b1;
        z_rom_oe_n = 1'b1;

        // Reload from DONE repeats the copy.
        @(posedge clk);
        #1;
        push_copy();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check("rl_done", 32'(done), 32'd0);
        check("rl_z88", 32'(z88_rst_n), 32'd0);
        check("rl_busy", 32'(busy), 32'd1);
        check("rl_state", 32'(dbg_state), 32'd1);
        wait_done(1, 1'b0, cyc);
        check("rl_latency", 32'(cyc), 32'(DONE_AT));
        check("rl_checksum", 32'(checksum), 32'(first_sum));
        check("rl_sb_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a write pulse.
        @(posedge clk);
        #1;
        push_copy();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        repeat (30) @(posedge clk);
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dbg_state == 3'd3) break;
        end
        check("wpulse_seen", 32'(dbg_state), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_we", 32'(sram_we_n), 32'd1);
        check("arst_z88", 32'(z88_rst_n), 32'd0);
        check("arst_sram_a", 32'(sram_a), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        push_copy();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_fl_a", 32'(fl_a), 32'(SRC));
        check("restart_fl_oe", 32'(fl_oe_n), 32'd0);
        check("restart_state", 32'(dbg_state), 32'd1);
        wait_done(1, 1'b0, cyc);
        check("restart_latency", 32'(cyc), 32'(DONE_AT));
        check("restart_sum", 32'(checksum), 32'(first_sum));
        check("restart_sb_left", 32'(exp_q.size()), 32'd0);

        check("ce_overlap", 32'(overlap_cnt), 32'd0);
        check("addr_data_stable", 32'(unstable_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
